// File: rtl/spi_xfer_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_arbiter_pkg
// Description : Shared constants and helper for the serial-read arbiter.
//               The constants are the scaler width and the FSM state
//               encodings. The helper sanitises the clock scaler.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_xfer_arbiter_pkg;

  // Width of the base_fsm clk_scaler bus.
  localparam int c_SCALER_W = 8;

  // Arbiter FSM state encodings.
  localparam int         c_STATE_W      = 3;
  localparam logic [2:0] c_ST_IDLE      = 3'd0;
  localparam logic [2:0] c_ST_START     = 3'd1;
  localparam logic [2:0] c_ST_WAIT_LOW  = 3'd2;
  localparam logic [2:0] c_ST_WAIT_HIGH = 3'd3;
  localparam logic [2:0] c_ST_DONE      = 3'd4;

  // A scaler of zero would stall base_fsm, so it is promoted to one.
  function automatic logic [c_SCALER_W-1:0] fix_scaler(input logic [c_SCALER_W-1:0] s);
    return (s == '0) ? c_SCALER_W'(1) : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_xfer_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_arbiter_rr_pick
// Description : Combinational round-robin priority picker. It scans the
//               requesters in the order rr_ptr, rr_ptr+1, ... (mod N). The
//               first requester with its req bit set wins.
// Ports       : req[N-1:0]       in  - request vector
//               rr_ptr[IDW-1:0]  in  - highest-priority requester this round
//               gnt_id[IDW-1:0]  out - winning requester (0 when none)
//               any              out - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_arbiter_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] rr_ptr,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);

  logic [IDW-1:0] w_idx;

  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    w_idx  = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = IDW'((int'(rr_ptr) + i) % N);
      if (!any && req[w_idx]) begin
        any    = 1'b1;
        gnt_id = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_xfer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_arbiter
// Description : Shares one base_fsm serial-read engine between N requesters.
//               Arbitration is round-robin. Each grant produces exactly one
//               transfer: a start pulse, a held clk_scaler, and tracking of
//               cs_n low then high. The captured byte returns with done.
// Ports       : clk, rst            - clock, async active-high reset
//               req[N]              - per-requester level request
//               req_scaler[N*W]     - per-requester clk_scaler, slot i at i*W
//               done/done_id/rd_data/err - completion pulse and result
//               busy                - transfer in progress
//               fsm_start/fsm_clk_scaler - drive to base_fsm
//               fsm_cs_n/fsm_data   - status and byte from base_fsm
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_arbiter
  import spi_xfer_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req,
  input  logic [N*c_SCALER_W-1:0] req_scaler,
  output logic                    done,
  output logic [IDW-1:0]          done_id,
  output logic [7:0]              rd_data,
  output logic                    err,
  output logic                    busy,
  output logic                    fsm_start,
  output logic [c_SCALER_W-1:0]   fsm_clk_scaler,
  input  logic                    fsm_cs_n,
  input  logic [7:0]              fsm_data
);

  localparam int c_CNT_W = $clog2(TIMEOUT + 1);

  logic [c_STATE_W-1:0]  r_state;
  logic [IDW-1:0]        r_rr_ptr;
  logic [IDW-1:0]        r_gnt_id;
  logic [c_SCALER_W-1:0] r_scaler;
  logic [7:0]            r_rd_data;
  logic                  r_err;
  logic [c_CNT_W-1:0]    r_cnt;

  logic [IDW-1:0]        w_pick_id;
  logic                  w_any;
  logic [c_SCALER_W-1:0] w_slot_scaler;
  logic                  w_timeout;

  spi_xfer_arbiter_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .gnt_id (w_pick_id),
    .any    (w_any)
  );

  assign w_slot_scaler = req_scaler[w_pick_id*c_SCALER_W +: c_SCALER_W];
  // The last allowed wait cycle is the TIMEOUT-th cycle spent in the state.
  assign w_timeout     = (r_cnt == c_CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_ST_IDLE;
      r_rr_ptr  <= '0;
      r_gnt_id  <= '0;
      r_scaler  <= c_SCALER_W'(1);
      r_rd_data <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          // Hold off while cs_n is low. This covers a base_fsm that is still
          // finishing a transfer that was cut short by a reset here.
          if (w_any && fsm_cs_n) begin
            r_gnt_id <= w_pick_id;
            r_scaler <= fix_scaler(w_slot_scaler);
            r_err    <= 1'b0;
            r_state  <= c_ST_START;
          end
        end
        c_ST_START: begin
          r_cnt   <= '0;
          r_state <= c_ST_WAIT_LOW;
        end
        c_ST_WAIT_LOW: begin
          if (!fsm_cs_n) begin
            r_cnt   <= '0;
            r_state <= c_ST_WAIT_HIGH;
          end else if (w_timeout) begin
            r_err     <= 1'b1;
            r_rd_data <= 8'h00;
            r_state   <= c_ST_DONE;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        c_ST_WAIT_HIGH: begin
          if (fsm_cs_n) begin
            r_rd_data <= fsm_data;
            r_state   <= c_ST_DONE;
          end else if (w_timeout) begin
            r_err     <= 1'b1;
            r_rd_data <= 8'h00;
            r_state   <= c_ST_DONE;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        c_ST_DONE: begin
          r_rr_ptr <= (r_gnt_id == IDW'(N - 1)) ? '0 : r_gnt_id + IDW'(1);
          r_state  <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign fsm_start      = (r_state == c_ST_START);
  assign busy           = (r_state != c_ST_IDLE);
  assign done           = (r_state == c_ST_DONE);
  assign err            = (r_state == c_ST_DONE) && r_err;
  assign done_id        = r_gnt_id;
  assign rd_data        = r_rd_data;
  assign fsm_clk_scaler = r_scaler;

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_xfer_arbiter
// Description : Self-checking bench for spi_xfer_arbiter. A behavioural
//               base_fsm stub drives cs_n and data. Expected grants are
//               queued when requests are driven and popped at each done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_arbiter;
  import spi_xfer_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TMO = 32;
  localparam int W   = c_SCALER_W;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_scaler = '0;
  logic           done, err, busy, fsm_start;
  logic [IDW-1:0] done_id;
  logic [7:0]     rd_data;
  logic [W-1:0]   fsm_clk_scaler;
  logic           fsm_cs_n = 1'b1;
  logic [7:0]     fsm_data = 8'h00;

  always #10 clk = ~clk;

  spi_xfer_arbiter #(.N(N), .IDW(IDW), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_scaler     (req_scaler),
    .done           (done),
    .done_id        (done_id),
    .rd_data        (rd_data),
    .err            (err),
    .busy           (busy),
    .fsm_start      (fsm_start),
    .fsm_clk_scaler (fsm_clk_scaler),
    .fsm_cs_n       (fsm_cs_n),
    .fsm_data       (fsm_data)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic           err;
    logic [W-1:0]   scaler;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] data_q[$];
  int         n_vec = 0;
  int         n_miss = 0;

  // base_fsm stub: cs_n drops 2 cycles after start, stays low low_len cycles.
  bit stuck = 1'b0;
  int low_len = 4;
  int ph = 0;
  int cnt = 0;
  always @(posedge clk) begin
    case (ph)
      0: if (fsm_start === 1'b1 && !stuck) begin ph <= 1; cnt <= 2; end
      1: if (cnt == 1) begin
           fsm_cs_n <= 1'b0;
           fsm_data <= 8'($urandom);
           ph <= 2;
           cnt <= low_len;
         end else cnt <= cnt - 1;
      default: if (cnt == 1) begin
           fsm_cs_n <= 1'b1;
           data_q.push_back(fsm_data);
           ph <= 0;
         end else cnt <= cnt - 1;
    endcase
  end

  // Records start pulses and the scaler presented with them.
  int         start_cnt = 0;
  logic [W-1:0] last_scaler = '0;
  always @(posedge clk) begin
    if (fsm_start === 1'b1) begin
      start_cnt   = start_cnt + 1;
      last_scaler = fsm_clk_scaler;
    end
  end

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    data_q.delete();
    @(negedge clk);
    n_vec++;
    if ({done, err, busy, fsm_start, done_id, rd_data} !== '0 || fsm_clk_scaler !== W'(1)) begin
      n_miss++;
      $display("FAIL reset_state: done=%b err=%b busy=%b start=%b id=%0d data=%h scaler=%0d, want all 0 and scaler 1",
               done, err, busy, fsm_start, done_id, rd_data, fsm_clk_scaler);
    end
  endtask

  task automatic test_single();
    exp_t e; bit ok; int s0; logic [7:0] d;
    s0 = start_cnt;
    req_scaler[0*W +: W] = W'(6);
    req = 4'b0001;
    exp_q.push_back('{id: 2'd0, err: 1'b0, scaler: W'(6)});
    @(negedge clk);
    n_vec++;
    if (fsm_start !== 1'b1 || busy !== 1'b1) begin
      n_miss++;
      $display("FAIL single_start_latency: start=%b busy=%b, want 1 1", fsm_start, busy);
    end
    wait_done(200, ok);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL single_done_wait: no done within budget, want done");
    end else begin
      e = exp_q.pop_front();
      d = (data_q.size() > 0) ? data_q.pop_front() : 8'hxx;
      if (done_id !== e.id || err !== e.err || rd_data !== d || busy !== 1'b1) begin
        n_miss++;
        $display("FAIL single_result: id=%0d err=%b data=%h busy=%b, want id=%0d err=%b data=%h busy=1",
                 done_id, err, rd_data, busy, e.id, e.err, d);
      end
      n_vec++;
      if (start_cnt !== s0 + 1 || last_scaler !== e.scaler) begin
        n_miss++;
        $display("FAIL single_start: starts=%0d scaler=%0d, want starts=%0d scaler=%0d",
                 start_cnt - s0, last_scaler, 1, e.scaler);
      end
    end
    req = '0;
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL single_done_pulse: done=%b busy=%b after done, want 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; bit ok; int s0; logic [7:0] d;
    logic [IDW-1:0] ids [5];
    ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req_scaler = {W'(40), W'(30), W'(20), W'(10)};
    for (int k = 0; k < 5; k++)
      exp_q.push_back('{id: ids[k], err: 1'b0, scaler: W'(10 * (int'(ids[k]) + 1))});
    s0 = start_cnt;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(200, ok);
      n_vec++;
      if (!ok) begin
        n_miss++;
        $display("FAIL b2b_done_wait[%0d]: no done within budget, want done", k);
        break;
      end
      e = exp_q.pop_front();
      d = (data_q.size() > 0) ? data_q.pop_front() : 8'hxx;
      if (done_id !== e.id || err !== e.err || rd_data !== d) begin
        n_miss++;
        $display("FAIL b2b_result[%0d]: id=%0d err=%b data=%h, want id=%0d err=%b data=%h",
                 k, done_id, err, rd_data, e.id, e.err, d);
      end
      n_vec++;
      if (start_cnt !== s0 + 1 || last_scaler !== e.scaler || fsm_clk_scaler !== e.scaler) begin
        n_miss++;
        $display("FAIL b2b_scaler[%0d]: starts=%0d start_scaler=%0d scaler=%0d, want starts=1 scaler=%0d",
                 k, start_cnt - s0, last_scaler, fsm_clk_scaler, e.scaler);
      end
      if (k == 4) begin
        req = '0;
      end else begin
        @(negedge clk);
        n_vec++;
        if (fsm_start !== 1'b0) begin
          n_miss++;
          $display("FAIL b2b_gap1[%0d]: start=%b one cycle after done, want 0", k, fsm_start);
        end
        s0 = start_cnt;
        @(negedge clk);
        n_vec++;
        if (fsm_start !== 1'b1) begin
          n_miss++;
          $display("FAIL b2b_gap2[%0d]: start=%b two cycles after done, want 1", k, fsm_start);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    exp_t e; bit ok; logic [7:0] d;
    logic [N-1:0]   reqs [3];
    logic [IDW-1:0] ids  [3];
    reqs = '{4'b0100, 4'b0100, 4'b0101};
    ids  = '{2'd2, 2'd2, 2'd0};
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{id: ids[k], err: 1'b0, scaler: W'(10 * (int'(ids[k]) + 1))});
      req = reqs[k];
      wait_done(200, ok);
      n_vec++;
      if (!ok) begin
        n_miss++;
        $display("FAIL wrap_done_wait[%0d]: no done within budget, want done", k);
        req = '0;
        break;
      end
      e = exp_q.pop_front();
      d = (data_q.size() > 0) ? data_q.pop_front() : 8'hxx;
      if (done_id !== e.id || err !== e.err || rd_data !== d || fsm_clk_scaler !== e.scaler) begin
        n_miss++;
        $display("FAIL wrap_result[%0d]: id=%0d err=%b data=%h scaler=%0d, want id=%0d err=%b data=%h scaler=%0d",
                 k, done_id, err, rd_data, fsm_clk_scaler, e.id, e.err, d, e.scaler);
      end
      req = '0;
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    exp_t e; bit ok; int k;
    stuck = 1'b1;
    req = 4'b0010;
    exp_q.push_back('{id: 2'd1, err: 1'b1, scaler: W'(20)});
    @(negedge clk);
    n_vec++;
    if (fsm_start !== 1'b1) begin
      n_miss++;
      $display("FAIL timeout_start: start=%b, want 1", fsm_start);
    end
    k = 0;
    ok = 1'b0;
    for (int i = 0; i < TMO + 20; i++) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    n_vec++;
    if (!ok || k != TMO + 1) begin
      n_miss++;
      $display("FAIL timeout_latency: done after %0d cycles (seen=%b), want %0d", k, ok, TMO + 1);
    end
    if (ok) begin
      e = exp_q.pop_front();
      n_vec++;
      if (done_id !== e.id || err !== e.err || rd_data !== 8'h00 || fsm_clk_scaler !== e.scaler) begin
        n_miss++;
        $display("FAIL timeout_result: id=%0d err=%b data=%h scaler=%0d, want id=%0d err=1 data=00 scaler=%0d",
                 done_id, err, rd_data, fsm_clk_scaler, e.id, e.scaler);
      end
    end
    req = '0;
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || err !== 1'b0) begin
      n_miss++;
      $display("FAIL timeout_err_pulse: done=%b err=%b after done, want 0 0", done, err);
    end
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e; bit ok; bit bad; bit high; logic [7:0] d;
    low_len = 20;
    req = 4'b0100;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fsm_cs_n === 1'b0) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (!ok || busy !== 1'b0 || fsm_start !== 1'b0 || done !== 1'b0 || fsm_clk_scaler !== W'(1)) begin
      n_miss++;
      $display("FAIL rstmid_outputs: cs_low_seen=%b busy=%b start=%b done=%b scaler=%0d, want 1 0 0 0 1",
               ok, busy, fsm_start, done, fsm_clk_scaler);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    high = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (fsm_cs_n === 1'b1) begin high = 1'b1; break; end
      if (fsm_start !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_vec++;
    if (bad || !high || fsm_start !== 1'b0) begin
      n_miss++;
      $display("FAIL rstmid_hold: activity=%b cs_high=%b start=%b while engine busy, want 0 1 0",
               bad, high, fsm_start);
    end
    data_q.delete();
    low_len = 4;
    exp_q.push_back('{id: 2'd2, err: 1'b0, scaler: W'(30)});
    @(negedge clk);
    n_vec++;
    if (fsm_start !== 1'b1) begin
      n_miss++;
      $display("FAIL rstmid_restart: start=%b after cs_n high, want 1", fsm_start);
    end
    wait_done(200, ok);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL rstmid_done_wait: no done within budget, want done");
    end else begin
      e = exp_q.pop_front();
      d = (data_q.size() > 0) ? data_q.pop_front() : 8'hxx;
      if (done_id !== e.id || err !== e.err || rd_data !== d || fsm_clk_scaler !== e.scaler) begin
        n_miss++;
        $display("FAIL rstmid_result: id=%0d err=%b data=%h scaler=%0d, want id=%0d err=%b data=%h scaler=%0d",
                 done_id, err, rd_data, fsm_clk_scaler, e.id, e.err, d, e.scaler);
      end
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_drop_zero_scaler();
    exp_t e; bit ok; logic [7:0] d;
    req_scaler[1*W +: W] = '0;
    req = 4'b0010;
    exp_q.push_back('{id: 2'd1, err: 1'b0, scaler: W'(1)});
    @(negedge clk);
    n_vec++;
    if (fsm_start !== 1'b1 || fsm_clk_scaler !== W'(1)) begin
      n_miss++;
      $display("FAIL drop_start: start=%b scaler=%0d, want 1 1", fsm_start, fsm_clk_scaler);
    end
    repeat (3) @(negedge clk);
    req = '0;
    wait_done(200, ok);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL drop_done_wait: no done within budget, want done");
    end else begin
      e = exp_q.pop_front();
      d = (data_q.size() > 0) ? data_q.pop_front() : 8'hxx;
      if (done_id !== e.id || err !== e.err || rd_data !== d || fsm_clk_scaler !== e.scaler) begin
        n_miss++;
        $display("FAIL drop_result: id=%0d err=%b data=%h scaler=%0d, want id=%0d err=%b data=%h scaler=%0d",
                 done_id, err, rd_data, fsm_clk_scaler, e.id, e.err, d, e.scaler);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_reset();
    test_back_to_back();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_drop_zero_scaler();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
